// File: rtl/risc16_io_pkg.sv
// risc16_io_pkg: MMIO offsets and UART transmitter state type for the data-bus I/O page.
package risc16_io_pkg;
  localparam logic [7:0] UART_DATA   = 8'h00;
  localparam logic [7:0] UART_STATUS = 8'h02;
  localparam logic [7:0] CYCLE_LO    = 8'h04;
  localparam logic [7:0] CYCLE_HI    = 8'h06;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/risc16_uart_tx.sv
// risc16_uart_tx: buffered 8N1 transmitter with a small FIFO and a sticky overflow flag.
module risc16_uart_tx
  import risc16_io_pkg::*;
#(
  parameter int BAUD_DIV   = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       clr_ovf,
  output logic       txd,
  output logic       empty,
  output logic       full,
  output logic       busy,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(BAUD_DIV);
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] sh_q, sh_d;
  tx_state_t state_q, state_d;
  logic txd_q, txd_d, ovf_q, ovf_d, pop, push_ok, tick;
  logic [7:0] head;
  assign empty    = wp_q == rp_q;
  assign full     = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
  assign push_ok  = push & ~full;
  assign head     = mem_q[rp_q[AW-1:0]];
  assign tick     = baud_q == BW'(BAUD_DIV - 1);
  assign busy     = state_q != IDLE;
  assign txd      = txd_q;
  assign overflow = ovf_q;
  always_comb begin
    pop     = 1'b0;
    state_d = state_q;
    baud_d  = tick ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    sh_d    = sh_q;
    txd_d   = txd_q;
    case (state_q)
      IDLE: begin
        baud_d = '0;
        if (!empty) begin
          pop     = 1'b1;
          state_d = START;
          txd_d   = 1'b0;
          sh_d    = head;
        end
      end
      START: if (tick) begin
        state_d = DATA;
        txd_d   = sh_q[0];
        bit_d   = '0;
      end
      DATA: if (tick) begin
        if (bit_q == 3'd7) begin
          state_d = STOP;
          txd_d   = 1'b1;
        end else begin
          bit_d = bit_q + 3'd1;
          txd_d = sh_q[1];
          sh_d  = {1'b0, sh_q[7:1]};
        end
      end
      default: if (tick) begin
        // stop bit done: chain straight into the next start bit if data is waiting
        pop     = ~empty;
        state_d = empty ? IDLE : START;
        txd_d   = empty;
        sh_d    = head;
      end
    endcase
    wp_d  = wp_q + (AW+1)'(push_ok);
    rp_d  = rp_q + (AW+1)'(pop);
    ovf_d = clr_ovf ? 1'b0 : (ovf_q | (push & full));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      txd_q   <= 1'b1;
      ovf_q   <= 1'b0;
      wp_q    <= '0;
      rp_q    <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      txd_q   <= txd_d;
      ovf_q   <= ovf_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wp_q[AW-1:0]] <= push_data;
  end
endmodule

// File: rtl/risc16_dbus_io.sv
// risc16_dbus_io: data-bus decoder splitting RAM from the MMIO page (UART TX, cycle counter).
module risc16_dbus_io
  import risc16_io_pkg::*;
#(
  parameter logic [15:0] IO_BASE    = 16'hFF00,
  parameter int          BAUD_DIV   = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] daddr,
  input  logic [15:0] ddout,
  input  logic        doe,
  input  logic        dwe0,
  input  logic        dwe1,
  output logic [15:0] ddin,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_wdata,
  output logic        ram_oe,
  output logic        ram_we0,
  output logic        ram_we1,
  input  logic [15:0] ram_rdata,
  output logic        txd
);
  logic io_sel, wr, push, clr_ovf, clr_cnt, empty, full, busy, overflow;
  logic [7:0] off;
  logic [15:0] io_rdata;
  logic [31:0] cnt_q, cnt_d;
  assign io_sel    = daddr[15:8] == IO_BASE[15:8];
  assign off       = {daddr[7:1], 1'b0};
  assign wr        = (dwe0 | dwe1) & io_sel;
  assign push      = wr && off == UART_DATA;
  assign clr_ovf   = wr && off == UART_STATUS;
  assign clr_cnt   = wr && (off == CYCLE_LO || off == CYCLE_HI);
  assign ram_addr  = daddr;
  assign ram_wdata = ddout;
  assign ram_oe    = doe & ~io_sel;
  assign ram_we0   = dwe0 & ~io_sel;
  assign ram_we1   = dwe1 & ~io_sel;
  assign ddin      = io_sel ? io_rdata : ram_rdata;
  always_comb begin
    io_rdata = off == UART_STATUS ? {12'b0, overflow, busy, full, empty} :
               off == CYCLE_LO    ? cnt_q[15:0] :
               off == CYCLE_HI    ? cnt_q[31:16] : 16'h0000;
    cnt_d    = clr_cnt ? 32'd0 : cnt_q + 32'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end
  risc16_uart_tx #(.BAUD_DIV(BAUD_DIV), .FIFO_DEPTH(FIFO_DEPTH)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (dwe1 ? ddout[7:0] : ddout[15:8]),
    .clr_ovf   (clr_ovf),
    .txd       (txd),
    .empty     (empty),
    .full      (full),
    .busy      (busy),
    .overflow  (overflow)
  );
endmodule
